lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 197 +++++++++++++++++++
 tb/tb_lfsr_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_checker
// Description : Locks onto an incoming LFSR state stream, flags mismatches,
//               detects all-zero lockup and measures the sequence period.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
    parameter int                    DATA_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] TAPS       = 5'b10100,
    parameter int                    SYNC_LEN   = 4,
    parameter int                    CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear,
    output logic                  locked,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  stuck,
    output logic [CNT_WIDTH-1:0]  period,
    output logic                  period_valid
);

    localparam int c_MATCH_W = $clog2(SYNC_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] stored_q, stored_d;
    logic [DATA_WIDTH-1:0] expect_q, expect_d;
    logic [DATA_WIDTH-1:0] ref_q, ref_d;
    logic [c_MATCH_W-1:0]  match_q, match_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  miss_q, miss_d;
    logic                  locked_q, locked_d;
    logic                  error_q, error_d;
    logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
    logic                  stuck_q, stuck_d;
    logic [CNT_WIDTH-1:0]  period_q, period_d;
    logic                  period_valid_q, period_valid_d;

    function automatic logic [DATA_WIDTH-1:0] predict(input logic [DATA_WIDTH-1:0] cur);
        return {cur[DATA_WIDTH-2:0], ^(cur & TAPS)};
    endfunction

    logic                 w_is_zero;
    logic                 w_sync_hit;
    logic                 w_lock_hit;
    logic                 w_ref_hit;
    logic [c_MATCH_W-1:0] w_match_inc;
    logic                 w_cnt_full;
    logic                 w_err_full;

    assign w_is_zero   = (data_in == '0);
    assign w_sync_hit  = (data_in == predict(stored_q));
    assign w_lock_hit  = (data_in == expect_q);
    assign w_ref_hit   = (data_in == ref_q);
    assign w_match_inc = match_q + c_MATCH_W'(1);
    assign w_cnt_full  = &cnt_q;
    assign w_err_full  = &err_count_q;

    // Once locked, the comparison runs against a free-running expected value so a
    // single corrupted sample does not derail the following correct ones.
    always_comb begin
        state_d        = state_q;
        stored_d       = stored_q;
        expect_d       = expect_q;
        ref_d          = ref_q;
        match_d        = match_q;
        cnt_d          = cnt_q;
        miss_d         = miss_q;
        error_d        = 1'b0;
        err_count_d    = err_count_q;
        stuck_d        = stuck_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;

        if (clear) begin
            state_d        = IDLE;
            err_count_d    = '0;
            period_d       = '0;
            period_valid_d = 1'b0;
            stuck_d        = 1'b0;
            match_d        = '0;
            cnt_d          = '0;
            miss_d         = 1'b0;
        end else if (enable) begin
            stored_d = data_in;
            if (w_is_zero) begin
                state_d = IDLE;
                stuck_d = 1'b1;
                match_d = '0;
                miss_d  = 1'b0;
            end else begin
                stuck_d = 1'b0;
                case (state_q)
                    IDLE: begin
                        match_d = '0;
                        state_d = SYNC;
                    end
                    SYNC: begin
                        if (w_sync_hit) begin
                            match_d = w_match_inc;
                            if (w_match_inc == c_MATCH_W'(SYNC_LEN)) begin
                                state_d  = LOCKED;
                                ref_d    = data_in;
                                expect_d = predict(data_in);
                                cnt_d    = '0;
                                miss_d   = 1'b0;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                    LOCKED: begin
                        expect_d = predict(expect_q);
                        if (w_lock_hit) begin
                            miss_d = 1'b0;
                            if (w_ref_hit) begin
                                period_d       = w_cnt_full ? cnt_q : cnt_q + CNT_WIDTH'(1);
                                period_valid_d = 1'b1;
                                cnt_d          = '0;
                            end else if (!w_cnt_full) begin
                                cnt_d = cnt_q + CNT_WIDTH'(1);
                            end
                        end else begin
                            error_d = 1'b1;
                            if (!w_err_full) begin
                                err_count_d = err_count_q + CNT_WIDTH'(1);
                            end
                            if (miss_q) begin
                                state_d = SYNC;
                                match_d = '0;
                                miss_d  = 1'b0;
                            end else begin
                                miss_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            stored_q       <= '0;
            expect_q       <= '0;
            ref_q          <= '0;
            match_q        <= '0;
            cnt_q          <= '0;
            miss_q         <= 1'b0;
            locked_q       <= 1'b0;
            error_q        <= 1'b0;
            err_count_q    <= '0;
            stuck_q        <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            stored_q       <= stored_d;
            expect_q       <= expect_d;
            ref_q          <= ref_d;
            match_q        <= match_d;
            cnt_q          <= cnt_d;
            miss_q         <= miss_d;
            locked_q       <= locked_d;
            error_q        <= error_d;
            err_count_q    <= err_count_d;
            stuck_q        <= stuck_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
        end
    end

    assign locked       = locked_q;
    assign error        = error_q;
    assign err_count    = err_count_q;
    assign stuck        = stuck_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_checker
// Description : Directed scenarios plus random stream against a sequence-table
//               model of the checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;

    localparam int SYNC_LEN = 4;
    localparam int S_IDLE = 0, S_SYNC = 1, S_LOCK = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [4:0] data_in;
    logic       clear;
    logic       locked, error, stuck, period_valid;
    logic [7:0] err_count, period;

    always #5 clk = ~clk;

    lfsr_checker #(
        .DATA_WIDTH(5), .TAPS(5'b10100), .SYNC_LEN(SYNC_LEN), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in), .clear(clear),
        .locked(locked), .error(error), .err_count(err_count), .stuck(stuck),
        .period(period), .period_valid(period_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    // The full maximal-length sequence, with each state's position in it
    logic [4:0] seq [31];
    int         pos [32];
    int         sp;

    int m_state, m_last, m_ref, m_phase, m_match, m_cnt, m_miss;
    int m_error, m_errc, m_stuck, m_period, m_pv;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int succ(input int x);
        if (x == 0) return 0;
        return int'(seq[(pos[x] + 1) % 31]);
    endfunction

    function automatic int sat_inc(input int x);
        return (x >= 255) ? 255 : x + 1;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_last = 0; m_ref = 0; m_phase = 0; m_match = 0;
        m_cnt = 0; m_miss = 0; m_error = 0; m_errc = 0; m_stuck = 0;
        m_period = 0; m_pv = 0;
    endtask

    task automatic model_step(input logic en, input logic [4:0] d, input logic clr);
        m_error = 0;
        if (clr) begin
            m_state = S_IDLE; m_errc = 0; m_period = 0; m_pv = 0; m_stuck = 0;
            m_match = 0; m_cnt = 0; m_miss = 0;
            return;
        end
        if (!en) return;
        if (d == 0) begin
            m_state = S_IDLE; m_stuck = 1; m_last = 0;
            return;
        end
        m_stuck = 0;
        if (m_state == S_IDLE) begin
            m_match = 0;
            m_state = S_SYNC;
        end else if (m_state == S_SYNC) begin
            if (int'(d) == succ(m_last)) begin
                m_match++;
                if (m_match == SYNC_LEN) begin
                    m_state = S_LOCK; m_ref = int'(d); m_phase = (pos[d] + 1) % 31;
                    m_cnt = 0; m_miss = 0;
                end
            end else begin
                m_match = 0;
            end
        end else begin
            if (d == seq[m_phase]) begin
                m_miss = 0;
                if (int'(d) == m_ref) begin
                    m_period = sat_inc(m_cnt); m_pv = 1; m_cnt = 0;
                end else begin
                    m_cnt = sat_inc(m_cnt);
                end
            end else begin
                m_error = 1;
                m_errc = sat_inc(m_errc);
                if (m_miss != 0) begin
                    m_state = S_SYNC; m_match = 0;
                end else begin
                    m_miss = 1;
                end
            end
            m_phase = (m_phase + 1) % 31;
        end
        m_last = int'(d);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("locked", locked, (m_state == S_LOCK));
            chk("error", error, m_error);
            chk("err_count", err_count, m_errc);
            chk("stuck", stuck, m_stuck);
            chk("period", period, m_period);
            chk("period_valid", period_valid, m_pv);
        end
    end

    task automatic cyc(input logic en, input logic [4:0] d, input logic clr);
        enable = en; data_in = d; clear = clr;
        @(posedge clk);
        model_step(en, d, clr);
        @(negedge clk);
    endtask

    task automatic feed(input int k);
        for (int i = 0; i < k; i++) begin
            cyc(1'b1, seq[sp % 31], 1'b0);
            sp++;
        end
    endtask

    task automatic do_async_reset();
        enable = 1'b0; clear = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_error", error, 0);
        chk("arst_err_count", err_count, 0);
        chk("arst_stuck", stuck, 0);
        chk("arst_period", period, 0);
        chk("arst_period_valid", period_valid, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] cur;
        int         j;
        int         r;
        rst_n = 1'b0; enable = 1'b0; data_in = '0; clear = 1'b0;
        model_reset();

        cur = 5'b10110;
        for (int i = 0; i < 31; i++) begin
            seq[i] = cur;
            pos[cur] = i;
            cur = {cur[3:0], cur[4] ^ cur[2]};
        end
        pos[0] = 0;
        chk("tbl_s1", seq[1], 5'b01100);
        chk("tbl_s2", seq[2], 5'b11001);
        chk("tbl_s3", seq[3], 5'b10011);
        chk("tbl_wrap", cur, 5'b10110);

        repeat (2) @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_period_valid", period_valid, 0);
        rst_n = 1'b1;
        cmp_on = 1'b1;

        // Lock on the stream seeded 10110
        sp = 0;
        feed(4);
        chk("s1_not_yet", locked, 0);
        feed(1);
        chk("s1_locked", locked, 1);
        chk("s1_no_error", error, 0);

        // One full period after lock
        feed(30);
        chk("s2_pv_before", period_valid, 0);
        feed(1);
        chk("s2_period", period, 31);
        chk("s2_pv", period_valid, 1);

        // Single corrupted sample
        cyc(1'b1, 5'b00001, 1'b0); sp++;
        chk("s3_error", error, 1);
        chk("s3_err_count", err_count, 1);
        feed(1);
        chk("s3_error_gone", error, 0);
        chk("s3_locked", locked, 1);
        chk("s3_err_count_hold", err_count, 1);

        // Two consecutive misses, then a consistent stream from a new point
        cyc(1'b0, 5'b0, 1'b1);
        sp = 0;
        feed(5);
        chk("s4_locked", locked, 1);
        cyc(1'b1, seq[(sp + 7) % 31], 1'b0); sp++;
        chk("s4_first_miss_locked", locked, 1);
        j = (sp + 10) % 31;
        cyc(1'b1, seq[j], 1'b0);
        chk("s4_err_count", err_count, 2);
        chk("s4_unlocked", locked, 0);
        sp = j + 1;
        feed(3);
        chk("s4_not_yet", locked, 0);
        feed(1);
        chk("s4_relocked", locked, 1);

        // All-zero lockup while locked
        cyc(1'b1, 5'b00000, 1'b0);
        chk("s5_stuck", stuck, 1);
        chk("s5_unlocked", locked, 0);
        chk("s5_err_count", err_count, 2);
        chk("s5_no_error", error, 0);
        cyc(1'b1, 5'b10110, 1'b0);
        chk("s5_stuck_clr", stuck, 0);
        sp = 1;
        feed(3);
        chk("s5_sync_not_yet", locked, 0);
        feed(1);
        chk("s5_locked_from_sync", locked, 1);

        // Asynchronous reset while locked, then clear beats enable
        do_async_reset();
        cyc(1'b1, 5'b10110, 1'b1);
        sp = 1;
        feed(4);
        chk("s6_sample_ignored", locked, 0);
        feed(1);
        chk("s6_locked", locked, 1);

        // Error counter saturation with lock held by alternating good samples
        for (int i = 0; i < 260; i++) begin
            cyc(1'b1, seq[(sp + 7) % 31], 1'b0); sp++;
            feed(1);
        end
        chk("sat_err_count", err_count, 255);
        chk("sat_locked", locked, 1);

        // Random stream
        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                feed(1);
            end else if (r < 65) begin
                cyc(1'b0, 5'($urandom), 1'b0);
            end else if (r < 75) begin
                cyc(1'b1, seq[(sp + 1 + int'($urandom_range(0, 29))) % 31], 1'b0); sp++;
            end else if (r < 78) begin
                cyc(1'b1, 5'b00000, 1'b0);
            end else if (r < 80) begin
                cyc(1'($urandom_range(0, 1)), 5'($urandom), 1'b1);
            end else if (r < 85) begin
                sp = int'($urandom_range(0, 30));
                feed(1);
            end else if (r < 86) begin
                do_async_reset();
            end else begin
                cyc(1'b1, 5'($urandom), 1'b0);
            end
        end

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
